// File: rtl/button_direction_ctrl.sv
// -----------------------------------------------------------------------------
// button_direction_ctrl
//
// Turns four raw push buttons into single, fixed-length one-hot move pulses
// for a game core. Each button is synchronized (two flops), debounced by an
// independent mismatch counter, and then a small FSM issues exactly one pulse
// per clean single-button press. Simultaneous multi-button presses are
// discarded with a one-cycle 'rejected' pulse. A press is never repeated while
// held, and a button that was already down while the core refused moves
// (enable low) has to be released before it can fire.
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive mismatching cycles before a debounced level
//                     flips (2 .. 2^20)
//   PULSE_CYCLES    : cycles a direction code is held per press (2 .. 255)
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous, active-high reset
//   btn_up     in   raw button -> direction 0001 (top)
//   btn_down   in   raw button -> direction 0010 (bottom)
//   btn_left   in   raw button -> direction 0100 (left)
//   btn_right  in   raw button -> direction 1000 (right)
//   enable     in   synchronous; game core accepts moves (sampled in ARMED)
//   direction  out  registered one-hot move code, 0000 when idle
//   rejected   out  registered one-cycle pulse on a multi-button press
// -----------------------------------------------------------------------------
module button_direction_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int PULSE_CYCLES    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       enable,
  output logic [3:0] direction,
  output logic       rejected
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]       HOLD_LAST = 8'(PULSE_CYCLES - 1);

  // Bit order matches the direction code, so a one-hot debounced vector is
  // directly the move code.
  logic [3:0] btn_raw;
  assign btn_raw = {btn_right, btn_left, btn_down, btn_up};

  // ---------------------------------------------------------------------------
  // Two-flop synchronizers
  // ---------------------------------------------------------------------------
  logic [3:0] sync1_reg;
  logic [3:0] sync2_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= 4'b0000;
      sync2_reg <= 4'b0000;
    end else begin
      sync1_reg <= btn_raw;
      sync2_reg <= sync1_reg;
    end
  end

  // ---------------------------------------------------------------------------
  // Debouncers: one counter per button. The counter runs while the
  // synchronized input disagrees with the debounced level and clears as soon
  // as they agree; reaching DEBOUNCE_CYCLES consecutive disagreements flips
  // the level.
  // ---------------------------------------------------------------------------
  logic [3:0] level;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_debounce
      logic [CNT_W-1:0] cnt_reg;
      logic             lvl_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_reg <= '0;
          lvl_reg <= 1'b0;
        end else if (sync2_reg[gi] != lvl_reg) begin
          if (cnt_reg == CNT_LAST) begin
            cnt_reg <= '0;
            lvl_reg <= ~lvl_reg;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end else begin
          cnt_reg <= '0;
        end
      end

      assign level[gi] = lvl_reg;
    end
  endgenerate

  logic any_high;
  logic one_high;
  assign any_high = |level;
  // Clearing the lowest set bit leaves zero only for a single set bit.
  assign one_high = any_high && ((level & (level - 4'd1)) == 4'b0000);

  // ---------------------------------------------------------------------------
  // Pulse FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_ARMED,
    ST_FIRE,
    ST_WAIT_RELEASE
  } state_t;

  state_t     state_reg,  state_next;
  logic [3:0] dir_reg,    dir_next;
  logic       rej_reg,    rej_next;
  logic [7:0] hold_reg,   hold_next;
  // Set when a button is down in ARMED while enable is low; such a press is
  // stale and must be released before anything can fire.
  logic       stale_reg,  stale_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_ARMED;
      dir_reg   <= 4'b0000;
      rej_reg   <= 1'b0;
      hold_reg  <= 8'd0;
      stale_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      dir_reg   <= dir_next;
      rej_reg   <= rej_next;
      hold_reg  <= hold_next;
      stale_reg <= stale_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    dir_next   = dir_reg;
    rej_next   = 1'b0;
    hold_next  = hold_reg;
    stale_next = stale_reg;

    case (state_reg)
      ST_ARMED: begin
        dir_next  = 4'b0000;
        hold_next = 8'd0;
        if (!any_high) begin
          stale_next = 1'b0;
        end
        if (!enable) begin
          if (any_high) begin
            stale_next = 1'b1;
          end
        end else if (!stale_reg && any_high) begin
          if (one_high) begin
            state_next = ST_FIRE;
            dir_next   = level;
          end else begin
            state_next = ST_WAIT_RELEASE;
            rej_next   = 1'b1;
          end
        end
      end

      ST_FIRE: begin
        // Code is frozen here; enable and buttons are deliberately ignored.
        if (hold_reg == HOLD_LAST) begin
          state_next = ST_WAIT_RELEASE;
          dir_next   = 4'b0000;
          hold_next  = 8'd0;
        end else begin
          hold_next = hold_reg + 8'd1;
        end
      end

      ST_WAIT_RELEASE: begin
        dir_next   = 4'b0000;
        stale_next = 1'b0;
        if (!any_high) begin
          state_next = ST_ARMED;
        end
      end

      default: begin
        state_next = ST_ARMED;
        dir_next   = 4'b0000;
        hold_next  = 8'd0;
        stale_next = 1'b0;
      end
    endcase
  end

  assign direction = dir_reg;
  assign rejected  = rej_reg;

endmodule
